// File: rtl/bcd_display_controller.sv
// bcd_display_controller
// Converts an N-bit unsigned binary value to four BCD digits with a
// sequential double-dabble engine (one bit per cycle). Finished results are
// committed to a double-buffered display register. A free-running scanner
// multiplexes that register onto an active-low 4-digit 7-segment display.
module bcd_display_controller #(
  parameter int N              = 13,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] bin_in,
  input  logic         bin_valid,
  output logic         bin_ready,
  input  logic         blank_lz,
  output logic         busy,
  output logic         done,
  output logic [3:0]   an,
  output logic [6:0]   seg
);

  localparam int                SCAN_W     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(REFRESH_CYCLES - 1);
  localparam logic [3:0]        SHIFT_LAST = 4'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r;
  logic [N-1:0]      bin_r;
  logic [15:0]       bcd_r;
  logic [3:0]        cnt_r;
  logic [15:0]       disp_r;
  logic [SCAN_W-1:0] scan_cnt_r;
  logic [1:0]        idx_r;

  logic [15:0]       bcd_adj_s;
  logic [16+N-1:0]   work_s;
  logic [15:0]       bcd_next_s;
  logic [N-1:0]      bin_next_s;
  logic [3:0]        digit_s;
  logic              blank_s;
  logic [3:0]        an_s;
  logic [6:0]        seg_s;

  // Double-dabble correction: a nibble of 5 or more would overflow a decimal
  // digit once doubled, so pre-add 3.
  function automatic logic [3:0] dabble(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      dabble = nib + 4'd3;
    end else begin
      dabble = nib;
    end
  endfunction

  // Active-low segment pattern, bit6 = a .. bit0 = g; non-decimal codes go dark.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step: correct every BCD nibble, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj_s  = {dabble(bcd_r[15:12]), dabble(bcd_r[11:8]),
                  dabble(bcd_r[7:4]),   dabble(bcd_r[3:0])};
    work_s     = {bcd_adj_s, bin_r} << 1;
    bcd_next_s = work_s[16+N-1:N];
    bin_next_s = work_s[N-1:0];
  end

  // Pick the digit for the current scan index and decide leading-zero blanking
  // (a digit blanks only if it and everything above it is zero; digit 0 never).
  always_comb begin
    digit_s = 4'd0;
    blank_s = 1'b0;
    an_s    = 4'b1111;
    case (idx_r)
      2'd0: begin
        digit_s = disp_r[3:0];
        an_s    = 4'b1110;
        blank_s = 1'b0;
      end
      2'd1: begin
        digit_s = disp_r[7:4];
        an_s    = 4'b1101;
        blank_s = blank_lz & (disp_r[15:4] == 12'd0);
      end
      2'd2: begin
        digit_s = disp_r[11:8];
        an_s    = 4'b1011;
        blank_s = blank_lz & (disp_r[15:8] == 8'd0);
      end
      2'd3: begin
        digit_s = disp_r[15:12];
        an_s    = 4'b0111;
        blank_s = blank_lz & (disp_r[15:12] == 4'd0);
      end
      default: begin
        digit_s = 4'd0;
        an_s    = 4'b1111;
        blank_s = 1'b1;
      end
    endcase
    if (blank_s) begin
      seg_s = 7'b1111111;
    end else begin
      seg_s = seg_code(digit_s);
    end
  end

  // Conversion FSM: accept in IDLE, run N dabble steps in SHIFT, commit the
  // result to the display register on the way into the one-cycle DONE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      bin_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bin_r     <= {N{1'b0}};
      bcd_r     <= 16'd0;
      cnt_r     <= 4'd0;
      disp_r    <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bin_valid) begin
            bin_r     <= bin_in;
            bcd_r     <= 16'd0;
            cnt_r     <= 4'd0;
            state_r   <= SHIFT;
            bin_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state_r   <= IDLE;
          end
        end
        SHIFT: begin
          bcd_r <= bcd_next_s;
          bin_r <= bin_next_s;
          if (cnt_r == SHIFT_LAST) begin
            disp_r  <= bcd_next_s;
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + 4'd1;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          done      <= 1'b0;
          bin_ready <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          bin_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Display scanner: on each refresh wrap, present the digit at the current
  // index and advance the index, so the first update after reset shows digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      idx_r      <= 2'd0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      idx_r      <= idx_r + 2'd1;
      an         <= an_s;
      seg        <= seg_s;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

endmodule
